// File: rtl/core_config_pkg.sv
// Shared core configuration: CSR address map, trap sequencer state encoding
// and the mstatus bit positions used when entering and leaving a trap.
package core_config_pkg;

  typedef enum logic [11:0] {
    r_NONE    = 12'h000,
    r_MSTATUS = 12'h300,
    r_MTVEC   = 12'h305,
    r_MEPC    = 12'h341,
    r_MCAUSE  = 12'h342,
    r_MTVAL   = 12'h343
  } csr_t;

  typedef enum logic [2:0] {
    IDLE,
    W_EPC,
    W_CAUSE,
    W_TVAL,
    W_STATUS,
    M_STATUS,
    REDIRECT
  } trap_state_t;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_MSB  = 12;
  localparam int MSTATUS_MPP_LSB  = 11;

endpackage

// File: rtl/trap_target_calc.sv
// Trap entry target from mtvec and mcause. Vectored interrupt dispatch is
// included only when TRAP_VECTORED_EN is defined; otherwise direct mode.
module trap_target_calc #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] cause,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] base;
  logic            unused_cause;

  assign base         = mtvec & ~XLEN'(3);
  assign unused_cause = ^cause;

`ifdef TRAP_VECTORED_EN
  always_comb begin
    target = base;
    if (mtvec[1:0] == 2'b01 && cause[XLEN-1])
      target = base + (XLEN'(cause[4:0]) << 2);
  end
`else
  assign target = base;
`endif

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / MRET sequencer driving the CSR write port and the
// fetch redirect. Vectored trap targets are enabled by TRAP_VECTORED_EN.
//
// state    | meaning
// IDLE     | waiting for trap_req / mret_req
// W_EPC    | flush, write mepc
// W_CAUSE  | write mcause
// W_TVAL   | write mtval
// W_STATUS | read-modify-write mstatus for trap entry
// M_STATUS | flush, read-modify-write mstatus for MRET
// REDIRECT | one-cycle fetch redirect to mtvec target or mepc
module trap_ctrl
  import core_config_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_val,
  input  logic            mret_req,
  output logic            busy,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            csr_we,
  output csr_t            csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output csr_t            csr_raddr,
  input  logic [XLEN-1:0] csr_rdata
);

  trap_state_t     state, state_nx;
  logic [XLEN-1:0] pc_q, cause_q, val_q;
  logic            mret_q;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] status_v;

  trap_target_calc #(.XLEN(XLEN)) u_target (
    .mtvec  (csr_rdata),
    .cause  (cause_q),
    .target (target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Request context is captured only on acceptance; later requests are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      cause_q <= '0;
      val_q   <= '0;
      mret_q  <= 1'b0;
    end else if (state == IDLE) begin
      if (trap_req) begin
        pc_q    <= trap_pc;
        cause_q <= trap_cause;
        val_q   <= trap_val;
        mret_q  <= 1'b0;
      end else if (mret_req) begin
        mret_q  <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (trap_req)      state_nx = W_EPC;
        else if (mret_req) state_nx = M_STATUS;
      end
      W_EPC:    state_nx = W_CAUSE;
      W_CAUSE:  state_nx = W_TVAL;
      W_TVAL:   state_nx = W_STATUS;
      W_STATUS: state_nx = REDIRECT;
      M_STATUS: state_nx = REDIRECT;
      REDIRECT: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state != IDLE);
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    csr_we         = 1'b0;
    csr_waddr      = r_NONE;
    csr_wdata      = '0;
    csr_raddr      = r_NONE;
    status_v       = csr_rdata;
    case (state)
      W_EPC: begin
        flush     = 1'b1;
        csr_we    = 1'b1;
        csr_waddr = r_MEPC;
        csr_wdata = pc_q & ~XLEN'(1);
      end
      W_CAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = r_MCAUSE;
        csr_wdata = cause_q;
      end
      W_TVAL: begin
        csr_we    = 1'b1;
        csr_waddr = r_MTVAL;
        csr_wdata = val_q;
      end
      W_STATUS: begin
        csr_raddr = r_MSTATUS;
        status_v[MSTATUS_MPIE_BIT] = csr_rdata[MSTATUS_MIE_BIT];
        status_v[MSTATUS_MIE_BIT]  = 1'b0;
        status_v[MSTATUS_MPP_MSB:MSTATUS_MPP_LSB] = 2'b11;
        csr_we    = 1'b1;
        csr_waddr = r_MSTATUS;
        csr_wdata = status_v;
      end
      M_STATUS: begin
        flush     = 1'b1;
        csr_raddr = r_MSTATUS;
        status_v[MSTATUS_MIE_BIT]  = csr_rdata[MSTATUS_MPIE_BIT];
        status_v[MSTATUS_MPIE_BIT] = 1'b1;
        status_v[MSTATUS_MPP_MSB:MSTATUS_MPP_LSB] = 2'b11;
        csr_we    = 1'b1;
        csr_waddr = r_MSTATUS;
        csr_wdata = status_v;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        if (mret_q) begin
          csr_raddr   = r_MEPC;
          redirect_pc = csr_rdata & ~XLEN'(1);
        end else begin
          csr_raddr   = r_MTVEC;
          redirect_pc = target;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: a behavioural CSR file answers reads, the
// stimulus pushes expected CSR writes/redirects, a negedge monitor compares.
module tb_trap_ctrl;
  import core_config_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trap_req, mret_req;
  logic [31:0] trap_pc, trap_cause, trap_val;
  logic        busy, flush, redirect_valid, csr_we;
  logic [31:0] redirect_pc, csr_wdata, csr_rdata;
  csr_t        csr_waddr, csr_raddr;

  trap_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .trap_req(trap_req), .trap_pc(trap_pc),
    .trap_cause(trap_cause), .trap_val(trap_val), .mret_req(mret_req),
    .busy(busy), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .csr_we(csr_we), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural CSR file
  logic [31:0] m_status = 0, m_tvec = 0, m_epc = 0, m_cause = 0, m_tval = 0;
  logic        host_we = 1'b0;
  csr_t        host_addr = r_NONE;
  logic [31:0] host_data = 0;

  always_comb begin
    case (csr_raddr)
      r_MSTATUS: csr_rdata = m_status;
      r_MTVEC:   csr_rdata = m_tvec;
      r_MEPC:    csr_rdata = m_epc;
      r_MCAUSE:  csr_rdata = m_cause;
      r_MTVAL:   csr_rdata = m_tval;
      default:   csr_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    csr_t        a;
    logic [31:0] d;
    a = host_we ? host_addr : csr_waddr;
    d = host_we ? host_data : csr_wdata;
    if (host_we || csr_we) begin
      case (a)
        r_MSTATUS: m_status <= d;
        r_MTVEC:   m_tvec   <= d;
        r_MEPC:    m_epc    <= d;
        r_MCAUSE:  m_cause  <= d;
        r_MTVAL:   m_tval   <= d;
        default: ;
      endcase
    end
  end

  typedef struct {
    bit          redir;
    csr_t        addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic exp_t mk(bit r, csr_t a, logic [31:0] d);
    exp_t e;
    e.redir = r; e.addr = a; e.data = d;
    return e;
  endfunction

  // Reference rules written from the architectural description of mstatus.
  function automatic logic [31:0] st_enter(logic [31:0] s);
    logic [31:0] mie = (s >> 3) & 32'h1;
    return (s & ~32'h0000_1888) | (mie << 7) | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] st_mret(logic [31:0] s);
    logic [31:0] mpie = (s >> 7) & 32'h1;
    return (s & ~32'h0000_1888) | (mpie << 3) | 32'h0000_0080 | 32'h0000_1800;
  endfunction

  function automatic logic [31:0] tgt(logic [31:0] tv, logic [31:0] c);
    logic [31:0] base = tv & ~32'h3;
`ifdef TRAP_VECTORED_EN
    if ((tv % 4) == 1 && c >= 32'h8000_0000) return base + 4 * (c % 32);
`endif
    return base;
  endfunction

  // Monitor: every CSR write or redirect must match the oldest expectation.
  always @(negedge clk) begin
    if (csr_we || redirect_valid) begin
      exp_t e;
      bit   r;
      csr_t a;
      logic [31:0] d;
      r = redirect_valid;
      a = redirect_valid ? csr_raddr : csr_waddr;
      d = redirect_valid ? redirect_pc : csr_wdata;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event redir=%0b addr=%h data=%h required=none", r, a, d);
      end else begin
        e = exp_q.pop_front();
        if (csr_we && redirect_valid || r != e.redir || a != e.addr || d != e.data) begin
          failures++;
          $display("FAIL event actual redir=%0b addr=%h data=%h required redir=%0b addr=%h data=%h",
                   r, a, d, e.redir, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic set_csr(csr_t a, logic [31:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_data = d;
    @(posedge clk); #1;
    host_we = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_redirect_valid", 32'(redirect_valid), 0);
    chk("rst_csr_we", 32'(csr_we), 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_csr_wdata", csr_wdata, 0);
    chk("rst_csr_waddr", 32'(csr_waddr), 32'(r_NONE));
    chk("rst_csr_raddr", 32'(csr_raddr), 32'(r_NONE));
  endtask

  // One request; poke re-asserts both requests mid-sequence (trap only).
  task automatic do_op(bit trap, bit mret, logic [31:0] pc, logic [31:0] cause,
                       logic [31:0] val, bit poke);
    int lat;
    if (trap) begin
      exp_q.push_back(mk(0, r_MEPC, pc & ~32'h1));
      exp_q.push_back(mk(0, r_MCAUSE, cause));
      exp_q.push_back(mk(0, r_MTVAL, val));
      exp_q.push_back(mk(0, r_MSTATUS, st_enter(m_status)));
      exp_q.push_back(mk(1, r_MTVEC, tgt(m_tvec, cause)));
    end else begin
      exp_q.push_back(mk(0, r_MSTATUS, st_mret(m_status)));
      exp_q.push_back(mk(1, r_MEPC, m_epc & ~32'h1));
    end
    @(negedge clk);
    trap_req = trap; mret_req = mret;
    trap_pc = pc; trap_cause = cause; trap_val = val;
    @(posedge clk); #1;
    trap_req = 0; mret_req = 0;
    trap_pc = $urandom; trap_cause = $urandom; trap_val = $urandom;
    chk("flush_busy_after_accept", {30'd0, flush, busy}, 32'h3);
    lat = 1;
    while (1) begin
      @(negedge clk);
      if (redirect_valid) break;
      if (lat >= 12) begin
        failures++;
        $display("FAIL redirect_timeout actual=none required=redirect");
        break;
      end
      @(posedge clk); #1;
      lat++;
      if (lat == 2) chk("flush_one_cycle", 32'(flush), 0);
      if (poke && lat == 2) begin trap_req = 1; mret_req = 1; end
      if (poke && lat == 3) begin trap_req = 0; mret_req = 0; end
    end
    chk("latency", lat, trap ? 5 : 2);
    @(posedge clk); #1;
    chk("idle_after_redirect", 32'(busy), 0);
  endtask

  initial begin
    logic [31:0] r, old_tval, old_status, old_cause;
    int sel;
    rst_n = 0; trap_req = 0; mret_req = 0;
    trap_pc = 0; trap_cause = 0; trap_val = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1;

    set_csr(r_MSTATUS, 32'h8);
    set_csr(r_MTVEC, 32'h1000_0200);
    do_op(1, 0, 32'h1000_0104, 32'h2, 32'hDEAD_BEEF, 0);
    chk("dir_mstatus_trap", m_status, 32'h1880);
    chk("dir_mepc", m_epc, 32'h1000_0104);

    set_csr(r_MEPC, 32'h1000_0108);
    do_op(0, 1, 0, 0, 0, 0);
    chk("dir_mstatus_mret", m_status, 32'h1888);

    do_op(1, 1, 32'h2000_0011, 32'h7, 32'h55, 0);
    do_op(1, 0, 32'h3000_0000, 32'h4, 32'h66, 1);

    set_csr(r_MTVEC, 32'h1000_0201);
    do_op(1, 0, 32'h1000_0300, 32'h8000_000B, 32'h0, 0);

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 3));
      set_csr(r_MSTATUS, $urandom);
      r = $urandom;
      set_csr(r_MTVEC, {r[31:2], 1'b0, r[0]});
      set_csr(r_MEPC, $urandom);
      r = $urandom;
      do_op(sel != 1, sel == 1 || sel == 3, $urandom, {r[31], 26'($urandom), r[4:0]},
            $urandom, sel == 2);
    end

    // Abort during W_CAUSE: mepc stands, nothing after it is written.
    old_tval = m_tval; old_status = m_status; old_cause = m_cause;
    exp_q.push_back(mk(0, r_MEPC, 32'h4000_0000));
    @(negedge clk);
    trap_req = 1; trap_pc = 32'h4000_0001; trap_cause = 32'h5; trap_val = 32'h1234;
    @(posedge clk); #1;
    trap_req = 0;
    @(posedge clk); #1;
    rst_n = 0;
    exp_q.delete();
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_mepc", m_epc, 32'h4000_0000);
    chk("abort_mcause", m_cause, old_cause);
    chk("abort_mtval", m_tval, old_tval);
    chk("abort_mstatus", m_status, old_status);
    chk("abort_busy", 32'(busy), 0);

    do_op(1, 0, 32'h5000_0040, 32'h3, 32'h77, 0);
    repeat (2) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001: The module SHALL have parameter XLEN, default 32, giving the data width of PC, cause, tval and CSR data.
REQ-002: The module SHALL have port clk, input, 1, core clock.
REQ-003: The module SHALL have port rst_n, input, 1, reset; one clock, reset asynchronous and active-low.
REQ-004: The module SHALL have port trap_req, input, 1, exception/interrupt request, sampled only in IDLE.
REQ-005: The module SHALL have port trap_pc, input, XLEN, PC of the trapping instruction.
REQ-006: The module SHALL have port trap_cause, input, XLEN, mcause value (bit XLEN-1 = interrupt).
REQ-007: The module SHALL have port trap_val, input, XLEN, mtval value.
REQ-008: The module SHALL have port mret_req, input, 1, MRET retire request, sampled only in IDLE.
REQ-009: The module SHALL have port busy, output, 1, high whenever state != IDLE.
REQ-010: The module SHALL have port flush, output, 1, one-cycle pipeline flush pulse.
REQ-011: The module SHALL have ports redirect_valid, output, 1, and redirect_pc, output, XLEN, giving the fetch redirect.
REQ-012: The module SHALL have ports csr_we, output, 1; csr_waddr, output, csr_t; csr_wdata, output, XLEN; all three form the CSR file write port.
REQ-013: The module SHALL have ports csr_raddr, output, csr_t, and csr_rdata, input, XLEN, forming a combinational same-cycle CSR read.

Function
REQ-014: The FSM SHALL use the states IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, M_STATUS and REDIRECT.
REQ-015: In IDLE with trap_req=1, the module SHALL latch trap_pc/cause/val, go to W_EPC, and pulse flush in the next cycle.
REQ-016: In IDLE with mret_req=1 and trap_req=0, the module SHALL go to M_STATUS and pulse flush in the next cycle.
REQ-017: If trap_req and mret_req are both 1 in IDLE, trap SHALL win and the MRET SHALL be dropped.
REQ-018: Requests asserted while busy=1 SHALL be ignored; the requester holds them until busy=0.
REQ-019: In W_EPC, the module SHALL write r_MEPC with trap_pc & ~1.
REQ-020: In W_CAUSE, the module SHALL write r_MCAUSE with the latched cause.
REQ-021: In W_TVAL, the module SHALL write r_MTVAL with the latched val.
REQ-022: In W_STATUS, the module SHALL read r_MSTATUS and write back MPIE(bit7) <= MIE(bit3), MIE <= 0, MPP(12:11) <= 2'b11, with all other bits unchanged.
REQ-023: In M_STATUS, the module SHALL read r_MSTATUS and write back MIE <= MPIE, MPIE <= 1, MPP <= 2'b11, with all other bits unchanged.
REQ-024: In REDIRECT after a trap, csr_raddr SHALL be r_MTVEC and redirect_pc SHALL equal the computed target; after MRET, csr_raddr SHALL be r_MEPC and redirect_pc SHALL equal csr_rdata & ~1.
REQ-025: redirect_valid SHALL be high for exactly one cycle, in REDIRECT, and the state SHALL then return to IDLE.
REQ-026: Latency SHALL be 5 cycles from trap acceptance to redirect_valid, and 2 cycles for MRET.
REQ-027: csr_we SHALL be high exactly once per write state and low otherwise.

Reset
REQ-028: On rst_n=0, state SHALL be IDLE and busy, flush, redirect_valid and csr_we SHALL be 0.
REQ-029: On rst_n=0, redirect_pc, csr_wdata and the latches SHALL be 0, and csr_waddr/csr_raddr SHALL be r_NONE.
REQ-030: On reset mid-sequence, the module SHALL abort immediately with no further writes; CSR writes already performed SHALL stand.

Configuration
REQ-031: The macro TRAP_VECTORED_EN SHALL control the trap target computation.
REQ-032: With TRAP_VECTORED_EN defined, if mtvec[1:0]=01 and cause bit XLEN-1=1, the target SHALL be (mtvec & ~3) + 4*cause[4:0]; otherwise it SHALL be mtvec & ~3.
REQ-033: Without TRAP_VECTORED_EN, the target SHALL always be mtvec & ~3.

Structure
REQ-034: trap_state_t, MSTATUS_MIE_BIT=3, MSTATUS_MPIE_BIT=7 and MSTATUS_MPP_MSB/LSB=12/11 SHALL be added to core_config_pkg; csr_t SHALL be reused from that package.
REQ-035: The target computation SHALL be one combinational sub-module, trap_target_calc.

Verification
REQ-036: Trap with pc=0x10000104, cause=2, val=0xDEADBEEF, mstatus=0x8, mtvec=0x10000200 -> writes MEPC=0x10000104, MCAUSE=2, MTVAL=0xDEADBEEF, MSTATUS=0x1880; redirect_pc=0x10000200 at cycle 5.
REQ-037: MRET with mstatus=0x1880, mepc=0x10000108 -> MSTATUS=0x1888 written; redirect_pc=0x10000108 at cycle 2.
REQ-038: Simultaneous trap_req and mret_req -> trap sequence only, with no M_STATUS write.
REQ-039: With TRAP_VECTORED_EN, mtvec=0x10000201 and cause=0x8000000B -> redirect_pc=0x1000022C; without the macro -> 0x10000200.
REQ-040: rst_n pulled low during W_CAUSE -> no MTVAL/MSTATUS write, outputs at reset values, MEPC keeps its new value.
REQ-041: trap_req pulsed while busy -> ignored, with exactly one redirect produced.
